// File: rtl/and_reduce_pipe.sv
// and_reduce_pipe: pipelined FANIN-ary AND tree over a WIDTH-bit word,
// with optional per-frame AND accumulation and per-word output invert.
module and_reduce_pipe #(
  parameter int WIDTH = 8,
  parameter int FANIN = 4,
  parameter int ACCUM = 0
) (
  input  logic             CK,
  input  logic             CD,
  input  logic             SP,
  input  logic             VI,
  input  logic             LI,
  input  logic             INV,
  input  logic [WIDTH-1:0] A,
  output logic             Z0,
  output logic             VO
);

  function automatic int terms(input int k);
    int n;
    n = WIDTH;
    for (int i = 0; i < k; i++) n = (n + FANIN - 1) / FANIN;
    return n;
  endfunction

  function automatic int n_stages();
    int n;
    int s;
    n = (WIDTH + FANIN - 1) / FANIN;
    s = 1;
    while (n > 1) begin
      n = (n + FANIN - 1) / FANIN;
      s++;
    end
    return s;
  endfunction

  localparam int S = n_stages();

  logic [WIDTH-1:0] lvl [S+1];
  logic [S:0]       v_c;
  logic [S:0]       i_c;
  logic [S:0]       l_c;
  logic [S:0]       unused_lvl;

  assign lvl[0]        = A;
  assign v_c[0]        = VI;
  assign i_c[0]        = INV;
  assign l_c[0]        = LI;
  assign unused_lvl[0] = 1'b0;

  for (genvar k = 1; k <= S; k++) begin : g_stg
    localparam int NI = terms(k - 1);
    localparam int NO = terms(k);
    localparam bit LAST_INV = (ACCUM == 0) && (k == S);

    logic [NO*FANIN-1:0] pad;
    logic [NO-1:0]       red;
    logic [NO-1:0]       dat_d;
    logic [NO-1:0]       dat_q;
    logic                vld_d;
    logic                vld_q;
    logic                inv_d;
    logic                inv_q;
    logic                lst_d;
    logic                lst_q;

    // missing terms of the last group read as 1
    always_comb begin
      pad         = '1;
      pad[NI-1:0] = lvl[k-1][NI-1:0];
    end

    for (genvar j = 0; j < NO; j++) begin : g_node
      assign red[j] = &pad[j*FANIN +: FANIN];
    end

    // data and side-band load only with an incoming valid word
    always_comb begin
      dat_d = dat_q;
      vld_d = vld_q;
      inv_d = inv_q;
      lst_d = lst_q;
      if (SP) begin
        vld_d = v_c[k-1];
        if (v_c[k-1]) begin
          dat_d = LAST_INV ? (red ^ {NO{i_c[k-1]}}) : red;
          inv_d = i_c[k-1];
          lst_d = l_c[k-1];
        end
      end
    end

    // stage registers; valid clears so in-flight words vanish on reset
    always_ff @(posedge CK or posedge CD) begin
      if (CD) begin
        dat_q <= '0;
        vld_q <= 1'b0;
        inv_q <= 1'b0;
        lst_q <= 1'b0;
      end else begin
        dat_q <= dat_d;
        vld_q <= vld_d;
        inv_q <= inv_d;
        lst_q <= lst_d;
      end
    end

    assign lvl[k]        = WIDTH'(dat_q);
    assign v_c[k]        = vld_q;
    assign i_c[k]        = inv_q;
    assign l_c[k]        = lst_q;
    assign unused_lvl[k] = ^lvl[k];
  end

  if (ACCUM != 0) begin : g_acc
    logic acc_d;
    logic acc_q;
    logic z_d;
    logic z_q;
    logic vo_d;
    logic vo_q;

    // fold each word into acc; emit and restart on the last word
    always_comb begin
      acc_d = acc_q;
      z_d   = z_q;
      vo_d  = vo_q;
      if (SP) begin
        vo_d = v_c[S] & l_c[S];
        if (v_c[S]) begin
          if (l_c[S]) begin
            z_d   = (acc_q & lvl[S][0]) ^ i_c[S];
            acc_d = 1'b1;
          end else begin
            acc_d = acc_q & lvl[S][0];
          end
        end
      end
    end

    // accumulator and output registers
    always_ff @(posedge CK or posedge CD) begin
      if (CD) begin
        acc_q <= 1'b1;
        z_q   <= 1'b0;
        vo_q  <= 1'b0;
      end else begin
        acc_q <= acc_d;
        z_q   <= z_d;
        vo_q  <= vo_d;
      end
    end

    assign Z0 = z_q;
    assign VO = vo_q;
  end else begin : g_dir
    logic unused_side;

    assign Z0          = lvl[S][0];
    assign VO          = v_c[S];
    assign unused_side = ^{i_c[S], l_c[S]};
  end

endmodule

// File: doc/and_reduce_pipe.md
AND_REDUCE_PIPE -- requirements
Module: and_reduce_pipe

Interface
REQ-001 Parameter WIDTH, default 8, meaning reduced input word width; legal range 1..256.
REQ-002 Parameter FANIN, default 4, meaning AND inputs per pipeline node; legal range 2..8.
REQ-003 Parameter ACCUM, default 0, meaning 0 = per-word reduction, 1 = AND-accumulate across a frame of words.
REQ-004 CK  input  1  clock; all state updates on rising edge.
REQ-005 CD  input  1  reset; asynchronous, active-high.
REQ-006 SP  input  1  clock enable; 0 freezes every register.
REQ-007 VI  input  1  input word valid.
REQ-008 LI  input  1  last word of frame; qualified by VI; ignored when ACCUM=0.
REQ-009 INV  input  1  per-word output invert (NAND behaviour); qualified by VI.
REQ-010 A  input  WIDTH  word to reduce.
REQ-011 Z0  output  1  registered reduction result.
REQ-012 VO  output  1  result valid, one-cycle pulse per result.

Function
REQ-013 The block SHALL have S = ceil(log_FANIN(WIDTH)) AND stages, with S = 1 when WIDTH <= FANIN.
REQ-014 Stage k SHALL register ceil(WIDTH/FANIN^k) partial ANDs, each of FANIN consecutive lower-stage terms; missing terms SHALL be padded with 1.
REQ-015 VI, INV and LI SHALL travel through the pipeline with their data; each stage's data registers SHALL load only when its incoming valid is 1.
REQ-016 ACCUM=0: a word captured on edge n (SP=1, VI=1) SHALL give VO=1 and Z0 = (&A) ^ INV after S SP-enabled edges; latency S.
REQ-017 ACCUM=1: one accumulator stage follows stage S; latency S+1; accumulator initial value 1.
REQ-018 ACCUM=1, valid result r with LI=0: acc <= acc & r; VO=0; Z0 holds.
REQ-019 ACCUM=1, valid result r with LI=1: Z0 <= (acc & r) ^ INV of that word; VO=1; acc <= 1 on the same edge.
REQ-020 Frame length SHALL be unbounded; a single-word frame (VI=1, LI=1) SHALL give Z0 = (&A) ^ INV.
REQ-021 Back-to-back valid words SHALL be accepted every SP-enabled cycle with no bubbles (throughput 1 word/cycle).
REQ-022 VO SHALL be 0 on every cycle without a new result; Z0 SHALL hold its last result while VO=0.
REQ-023 SP=0 SHALL hold all data, valid, accumulator and output registers; VO holds its value; on SP=1 the pipeline resumes exactly where it stopped.
REQ-024 The block SHALL NOT apply backpressure; upstream must gate VI with SP.

Reset
REQ-025 CD=1 SHALL asynchronously clear all pipeline valid bits, VO=0, Z0=0 and acc=1, regardless of CK and SP.
REQ-026 Partial data registers SHALL reset to 0; their value is not observable while valid bits are 0.
REQ-027 Words in flight and a partial frame at reset assertion SHALL be discarded with no VO pulse.
REQ-028 The first capture after reset SHALL occur on the first CK rising edge with CD=0 and SP=1.

Verification
REQ-029 WIDTH=8, FANIN=4 (S=2): A=8'hFF, VI=1, INV=0 -> VO=1, Z0=1 two edges later; A=8'hFE -> Z0=0.
REQ-030 A=8'hFF, INV=1 -> Z0=0; A=8'h00, INV=1 -> Z0=1.
REQ-031 Back-to-back words FF, 7F, FF -> VO high three consecutive cycles with Z0 = 1, 0, 1; idle cycles between words -> VO=0 and Z0 held.
REQ-032 SP=0 for 3 cycles with two words in flight -> outputs frozen; results appear 3 cycles later, values unchanged.
REQ-033 Padding: WIDTH=10, FANIN=4 (S=2): A=10'h3FF -> 1 and A=10'h1FF -> 0; WIDTH=17, FANIN=4 -> latency 3.
REQ-034 ACCUM=1, WIDTH=8: frame FF, FF, FF(LI) -> single VO with Z0=1, three edges after LI; frame FF, EF, FF(LI) -> Z0=0; CD pulse mid-frame then FF(LI) -> Z0=1, and no VO for the discarded frame.
